// File: rtl/row_result_serializer_if.sv
// Output element stream of the row result serializer.
interface row_result_serializer_if #(
  parameter int OUT_WIDTH = 8
);
  // A transfer happens on each rising clk edge where valid && ready. Once valid
  // is high, data and last hold steady until that transfer completes.
  logic                 valid;
  logic                 ready;
  logic                 last;
  logic [OUT_WIDTH-1:0] data;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/row_result_serializer.sv
// Captures a completed accumulator row and streams it out element by element,
// applying a rounding right shift and saturation to OUT_WIDTH bits.
module row_result_serializer #(
  parameter int NUM_ELEM    = 8,
  parameter int IN_WIDTH    = 16,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_done,
  input  logic [NUM_ELEM*IN_WIDTH-1:0] in_row,
  input  logic [SHIFT_WIDTH-1:0]       shift,
  row_result_serializer_if.master      out,
  output logic                         row_done,
  output logic                         busy,
  output logic                         overrun,
  output logic                         fsm_state
);

  localparam int              IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                        state;
  state_t                        state_next;
  logic                          done_q;
  logic                          armed;
  logic                          capture;
  logic                          valid;
  logic                          xfer;
  logic                          xfer_last;
  logic [IDX_W-1:0]              idx;
  logic [NUM_ELEM*IN_WIDTH-1:0]  row_q;
  logic [SHIFT_WIDTH-1:0]        shift_q;
  logic signed [IN_WIDTH-1:0]    elem;
  logic signed [IN_WIDTH:0]      wide;
  logic signed [IN_WIDTH:0]      rnd;
  logic signed [IN_WIDTH:0]      shifted;
  logic [IN_WIDTH-OUT_WIDTH+1:0] top;
  logic [OUT_WIDTH-1:0]          data_c;

  // armed blocks a capture until in_done has been seen low since reset, so a
  // level still high at reset release is not mistaken for a fresh edge.
  assign capture   = in_done && !done_q && armed;
  assign valid     = (state == STREAM);
  assign xfer      = valid && out.ready;
  assign xfer_last = xfer && (idx == LAST_IDX);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture)   state_next = STREAM;
      STREAM:  if (xfer_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      idx      <= '0;
      done_q   <= 1'b0;
      armed    <= !in_done;
      row_q    <= '0;
      shift_q  <= '0;
      row_done <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_next;
      done_q   <= in_done;
      armed    <= armed || !in_done;
      row_done <= xfer_last;
      if (capture && state == IDLE) begin
        row_q   <= in_row;
        shift_q <= shift;
        idx     <= '0;
      end else if (xfer) begin
        idx <= xfer_last ? '0 : idx + 1'b1;
      end
      if (capture && state == STREAM) overrun <= 1'b1;
    end
  end

  // Round half up, then arithmetic shift; one extra bit keeps the add exact.
  always_comb begin
    elem = row_q[IN_WIDTH*idx +: IN_WIDTH];
    wide = {elem[IN_WIDTH-1], elem};
    rnd  = '0;
    if (shift_q != '0) rnd = (IN_WIDTH+1)'(1) << (shift_q - 1'b1);
    shifted = (wide + rnd) >>> shift_q;
    top     = shifted[IN_WIDTH:OUT_WIDTH-1];
    if ((&top) || !(|top))   data_c = shifted[OUT_WIDTH-1:0];
    else if (shifted[IN_WIDTH]) data_c = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else                        data_c = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end

  assign out.valid = valid;
  assign out.last  = valid && (idx == LAST_IDX);
  assign out.data  = data_c;
  assign busy      = valid;
  assign fsm_state = (state == STREAM);

endmodule

// File: tb/tb_row_result_serializer.sv
// Directed bench for row_result_serializer: per-cycle checks plus a transfer
// scoreboard fed with hand-computed requantized elements.
module tb_row_result_serializer;

  localparam int NUM_ELEM    = 4;
  localparam int IN_WIDTH    = 16;
  localparam int OUT_WIDTH   = 8;
  localparam int SHIFT_WIDTH = 4;

  logic                         clk = 1'b0;
  logic                         rstn = 1'b0;
  logic                         in_done = 1'b0;
  logic [NUM_ELEM*IN_WIDTH-1:0] in_row = '0;
  logic [SHIFT_WIDTH-1:0]       shift = '0;
  logic                         row_done;
  logic                         busy;
  logic                         overrun;
  logic                         fsm_state;

  row_result_serializer_if #(.OUT_WIDTH(OUT_WIDTH)) out_if ();

  row_result_serializer #(
    .NUM_ELEM(NUM_ELEM), .IN_WIDTH(IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH)
  ) dut (
    .clk(clk), .rstn(rstn), .in_done(in_done), .in_row(in_row), .shift(shift),
    .out(out_if), .row_done(row_done), .busy(busy), .overrun(overrun),
    .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests_run    = 0;
  int tests_failed = 0;
  int xfer_cnt     = 0;
  int done_cnt     = 0;
  logic [OUT_WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every accepted element is compared with the next expected one
  always @(negedge clk) begin
    if (rstn && out_if.valid && out_if.ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) check("sb_extra_xfer", 32'(exp_q.size()), 32'd1);
      else check("sb_data", 32'(out_if.data), 32'(exp_q.pop_front()));
    end
    if (row_done) done_cnt++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
  endtask

  task automatic start_row(input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3,
                           input logic [3:0] sh);
    in_row  = {e3, e2, e1, e0};
    shift   = sh;
    in_done = 1'b1;
  endtask

  task automatic wait_row_done(input string tag);
    int n = 0;
    while (!row_done && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(row_done), 32'd1);
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"},    32'(out_if.valid), 32'd0);
    check({tag, "_last"},     32'(out_if.last),  32'd0);
    check({tag, "_busy"},     32'(busy),         32'd0);
    check({tag, "_row_done"}, 32'(row_done),     32'd0);
    check({tag, "_overrun"},  32'(overrun),      32'd0);
    check({tag, "_data"},     32'(out_if.data),  32'd0);
    check({tag, "_state"},    32'(fsm_state),    32'd0);
  endtask

  task automatic do_reset();
    rstn         = 1'b0;
    in_done      = 1'b0;
    out_if.ready = 1'b1;
    tick();
    tick();
    check_idle_outputs("reset");
    rstn = 1'b1;
    tick();
  endtask

  int x0;
  int d0;

  initial begin
    out_if.ready = 1'b1;

    // T1: saturation without shift, cycle-exact timing
    do_reset();
    x0 = xfer_cnt;
    push_row(8'd5, 8'hF9, 8'h7F, 8'h80);
    start_row(16'd5, -16'sd7, 16'd200, -16'sd300, 4'd0);
    tick();                                   // cycle 1
    in_done = 1'b0;
    check("t1_valid_c1", 32'(out_if.valid), 32'd1);
    check("t1_busy_c1",  32'(busy),         32'd1);
    check("t1_last_c1",  32'(out_if.last),  32'd0);
    tick(); tick(); tick();                   // cycle 4
    check("t1_last_c4",  32'(out_if.last),  32'd1);
    check("t1_valid_c4", 32'(out_if.valid), 32'd1);
    tick();                                   // cycle 5
    check("t1_row_done_c5", 32'(row_done),     32'd1);
    check("t1_valid_c5",    32'(out_if.valid), 32'd0);
    check("t1_busy_c5",     32'(busy),         32'd0);
    check("t1_last_c5",     32'(out_if.last),  32'd0);
    tick();                                   // cycle 6
    check("t1_row_done_c6", 32'(row_done), 32'd0);
    check("t1_xfers", 32'(xfer_cnt - x0), 32'd4);

    // T2: rounding shift; input changes mid-row must not leak through
    push_row(8'd3, 8'hFE, 8'd2, 8'h7F);
    start_row(16'd10, -16'sd10, 16'd7, 16'd1000, 4'd2);
    tick();
    in_done = 1'b0;
    in_row  = '1;
    shift   = 4'd0;
    wait_row_done("t2_row_done");

    // T3: backpressure on cycles 2-3 holds element 1 for three cycles
    push_row(8'd1, 8'd2, 8'd3, 8'd4);
    start_row(16'd1, 16'd2, 16'd3, 16'd4, 4'd0);
    tick();                                   // cycle 1
    in_done = 1'b0;
    tick();                                   // cycle 2
    out_if.ready = 1'b0;
    check("t3_hold_c2", 32'(out_if.data), 32'd2);
    tick();                                   // cycle 3
    check("t3_hold_c3",  32'(out_if.data),  32'd2);
    check("t3_valid_c3", 32'(out_if.valid), 32'd1);
    tick();                                   // cycle 4
    check("t3_hold_c4", 32'(out_if.data), 32'd2);
    out_if.ready = 1'b1;
    tick();                                   // cycle 5
    check("t3_next_c5", 32'(out_if.data), 32'd3);
    wait_row_done("t3_row_done");

    // T4: in_done held high produces one row only
    x0 = xfer_cnt;
    d0 = done_cnt;
    push_row(8'hFF, 8'h00, 8'h7F, 8'h80);
    start_row(-16'sd1, 16'd0, 16'd127, -16'sd129, 4'd0);
    repeat (20) tick();
    in_done = 1'b0;
    repeat (3) tick();
    check("t4_xfers",     32'(xfer_cnt - x0), 32'd4);
    check("t4_row_dones", 32'(done_cnt - d0), 32'd1);
    check("t4_overrun",   32'(overrun),       32'd0);
    check("t4_valid",     32'(out_if.valid),  32'd0);

    // T5: new edge during streaming sets sticky overrun, row completes intact
    push_row(8'd13, 8'd25, 8'd38, 8'd50);
    start_row(16'd100, 16'd200, 16'd300, 16'd400, 4'd3);
    tick();                                   // cycle 1
    tick();                                   // cycle 2
    in_done = 1'b0;
    tick();                                   // cycle 3
    in_done = 1'b1;
    in_row  = '0;
    shift   = 4'd0;
    check("t5_overrun_c3", 32'(overrun), 32'd0);
    tick();                                   // cycle 4
    check("t5_overrun_c4", 32'(overrun), 32'd1);
    in_done = 1'b0;
    wait_row_done("t5_row_done");
    check("t5_overrun_sticky", 32'(overrun), 32'd1);

    // T6a: edge on the last-transfer cycle is dropped
    do_reset();
    push_row(8'hC0, 8'h40, 8'h20, 8'hE0);
    start_row(-16'sd128, 16'd127, 16'd64, -16'sd64, 4'd1);
    tick();                                   // cycle 1
    in_done = 1'b0;
    tick(); tick(); tick();                   // cycle 4
    check("t6a_last_c4", 32'(out_if.last), 32'd1);
    in_done = 1'b1;
    tick();                                   // cycle 5
    check("t6a_overrun",  32'(overrun),      32'd1);
    check("t6a_row_done", 32'(row_done),     32'd1);
    check("t6a_valid_c5", 32'(out_if.valid), 32'd0);
    tick();                                   // cycle 6
    check("t6a_dropped", 32'(out_if.valid), 32'd0);
    in_done = 1'b0;
    tick();

    // T6b: edge in the ROW_DONE cycle is accepted
    push_row(8'd1, 8'd2, 8'd3, 8'd4);
    push_row(8'hFB, 8'h7F, 8'h80, 8'h00);
    start_row(16'd1, 16'd2, 16'd3, 16'd4, 4'd0);
    tick();                                   // cycle 1
    in_done = 1'b0;
    tick(); tick(); tick();                   // cycle 4
    tick();                                   // cycle 5
    check("t6b_row_done_c5", 32'(row_done), 32'd1);
    start_row(-16'sd5, 16'd300, -16'sd300, 16'd0, 4'd0);
    tick();                                   // cycle 6
    in_done = 1'b0;
    check("t6b_accept", 32'(out_if.valid), 32'd1);
    wait_row_done("t6b_row_done");

    // T7: reset mid-stream with in_done held high
    do_reset();
    d0 = done_cnt;
    out_if.ready = 1'b0;
    start_row(16'd7, 16'd7, 16'd7, 16'd7, 4'd0);
    tick();                                   // cycle 1
    check("t7_valid_c1", 32'(out_if.valid), 32'd1);
    tick();                                   // cycle 2
    rstn = 1'b0;
    tick();                                   // cycle 3
    check_idle_outputs("t7_rst");
    rstn = 1'b1;
    tick(); tick(); tick();
    check("t7_no_capture", 32'(out_if.valid), 32'd0);
    check("t7_no_row_done", 32'(done_cnt - d0), 32'd0);
    out_if.ready = 1'b1;
    in_done = 1'b0;
    tick();
    push_row(8'd9, 8'hF7, 8'd0, 8'd1);
    start_row(16'd9, -16'sd9, 16'd0, 16'd1, 4'd0);
    tick();
    in_done = 1'b0;
    check("t7_recapture", 32'(out_if.valid), 32'd1);
    wait_row_done("t7_row_done");

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/row_result_serializer.md
ROW_RESULT_SERIALIZER -- requirements
Module: row_result_serializer

Interface
REQ-001 Parameter NUM_ELEM, default 8: elements per captured row; equals upstream WEIGHT_COL.
REQ-002 Parameter IN_WIDTH, default 16: signed width of each upstream accumulator element.
REQ-003 Parameter OUT_WIDTH, default 8: signed width of each emitted element; equals downstream OP1_WIDTH.
REQ-004 Parameter SHIFT_WIDTH, default 4: width of the SHIFT control.
REQ-005 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 RSTN  input  1  reset, synchronous and active-low.
REQ-007 IN_DONE  input  1  upstream row-complete level; may stay high indefinitely.
REQ-008 IN_ROW  input  NUM_ELEM*IN_WIDTH  packed row; element k at bits [IN_WIDTH*k +: IN_WIDTH].
REQ-009 SHIFT  input  SHIFT_WIDTH  requantization right-shift amount, 0..IN_WIDTH-1.
REQ-010 OUT_VALID  output  1  OUT_DATA holds a valid element.
REQ-011 OUT_READY  input  1  downstream accepts the element this cycle.
REQ-012 OUT_DATA  output  OUT_WIDTH  signed requantized element.
REQ-013 OUT_LAST  output  1  high with OUT_VALID on element NUM_ELEM-1.
REQ-014 ROW_DONE  output  1  one-cycle pulse after the last element transfers.
REQ-015 BUSY  output  1  high while a captured row is being streamed.
REQ-016 OVERRUN  output  1  sticky: a row-complete edge arrived while BUSY.

Function
REQ-017 The block SHALL register IN_DONE each cycle and detect a capture event as IN_DONE=1 while the registered copy is 0 (rising edge only).
REQ-018 States SHALL be IDLE and STREAM; IDLE -> STREAM on a capture event; STREAM -> IDLE on the edge where OUT_VALID&OUT_READY&OUT_LAST.
REQ-019 On a capture event in IDLE the block SHALL latch IN_ROW and SHIFT, set element index to 0, and assert OUT_VALID and BUSY from the next cycle.
REQ-020 A transfer SHALL occur on each edge with OUT_VALID=1 and OUT_READY=1; each transfer increments the index by 1.
REQ-021 OUT_DATA and OUT_LAST SHALL be stable while OUT_VALID=1 and OUT_READY=0.
REQ-022 OUT_DATA for element k SHALL be: if SHIFT=0, element k; else (element k + 2^(SHIFT-1)) arithmetic-shifted right by SHIFT, computed in IN_WIDTH+1 bits without overflow.
REQ-023 The shifted result SHALL saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-024 After the last transfer OUT_VALID, OUT_LAST and BUSY SHALL be 0 the next cycle, and ROW_DONE SHALL be 1 for exactly that cycle.
REQ-025 Back-to-back throughput SHALL be one element per cycle when OUT_READY is held high: NUM_ELEM transfers in NUM_ELEM consecutive cycles.
REQ-026 A capture event in STREAM, including the last-transfer cycle, SHALL drop the new row and set OVERRUN; streaming of the current row continues unaffected.
REQ-027 A capture event in the cycle after ROW_DONE (state IDLE) SHALL be accepted normally.
REQ-028 Changes of IN_ROW or SHIFT while BUSY SHALL not affect emitted data.
REQ-029 OVERRUN SHALL clear only on reset.

Reset
REQ-030 While RSTN=0 at a rising edge: state IDLE, index 0, registered IN_DONE 0, OUT_VALID 0, OUT_LAST 0, ROW_DONE 0, BUSY 0, OVERRUN 0, OUT_DATA 0.
REQ-031 Reset mid-stream SHALL abandon the row without asserting ROW_DONE; if IN_DONE is high on release, no capture occurs until it falls and rises again.

Verification (NUM_ELEM=4, IN_WIDTH=16, OUT_WIDTH=8)
REQ-032 Row {5,-7,200,-300}, SHIFT=0, OUT_READY=1, IN_DONE rises at cycle 0 -> OUT_DATA 5,-7,127,-128 in cycles 1-4, OUT_LAST in cycle 4, ROW_DONE in cycle 5.
REQ-033 Row {10,-10,7,1000}, SHIFT=2 -> OUT_DATA 3,-2,2,127.
REQ-034 OUT_READY low on cycles 2-3 -> element 1 held stable on OUT_DATA for 3 cycles; all 4 elements emitted in order, none duplicated.
REQ-035 IN_DONE held high 20 cycles -> exactly one row (4 transfers) and one ROW_DONE pulse; OVERRUN stays 0.
REQ-036 IN_DONE falls at cycle 2 and rises at cycle 3 during streaming -> OVERRUN=1 from cycle 4, original row completes intact.
REQ-037 RSTN=0 at cycle 2 of streaming with IN_DONE high -> all outputs 0 next cycle; no ROW_DONE; no capture until a new IN_DONE rising edge.
